// File: rtl/bus_arbiter_if.sv
// Bus bundle between NUM_CLIENTS clients, the round-robin arbiter and a single server.
//   Client side : rq, address, wr_ni, dataW (client -> arbiter)
//                 ack, dataR, grant (arbiter -> clients)
//   Server side : srv_req, srv_address, srv_wr_ni, srv_dataW (arbiter -> server)
//                 srv_ack, srv_dataR (server -> arbiter)
// Modports:
//   slave  - the arbiter's view of the bus
//   master - the environment's view (clients and server)
interface bus_arbiter_if #(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4
);
  logic [NUM_CLIENTS-1:0]            rq;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] address;
  logic [NUM_CLIENTS-1:0]            wr_ni;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0] dataW;
  logic [NUM_CLIENTS-1:0]            ack;
  logic [DATA_WIDTH-1:0]             dataR;
  logic [NUM_CLIENTS-1:0]            grant;
  logic                              srv_req;
  logic [ADDR_WIDTH-1:0]             srv_address;
  logic                              srv_wr_ni;
  logic [DATA_WIDTH-1:0]             srv_dataW;
  logic                              srv_ack;
  logic [DATA_WIDTH-1:0]             srv_dataR;

  modport slave (
    input  rq, address, wr_ni, dataW, srv_ack, srv_dataR,
    output ack, dataR, grant, srv_req, srv_address, srv_wr_ni, srv_dataW
  );

  modport master (
    output rq, address, wr_ni, dataW, srv_ack, srv_dataR,
    input  ack, dataR, grant, srv_req, srv_address, srv_wr_ni, srv_dataW
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter between NUM_CLIENTS bus clients and a single server.
// One client is granted at a time; its request is registered towards the
// server, the arbiter waits for srv_ack, then pulses a one-cycle ack back to
// the client and spends one dead cycle before arbitrating again.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset (0 = reset)
//   bus   - bus_arbiter_if.slave: client request/ack bundle and server bundle
// All outputs are registered.
module bus_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  bus_arbiter_if.slave     bus
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SERVE   = 2'd1;
  localparam logic [1:0] ST_ACK     = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic [1:0]             state_q,       state_d;
  logic [IDX_W-1:0]       last_q,        last_d;
  logic [IDX_W-1:0]       owner_q,       owner_d;
  logic [NUM_CLIENTS-1:0] grant_q,       grant_d;
  logic [NUM_CLIENTS-1:0] ack_q,         ack_d;
  logic [DATA_WIDTH-1:0]  dataR_q,       dataR_d;
  logic                   srv_req_q,     srv_req_d;
  logic [ADDR_WIDTH-1:0]  srv_address_q, srv_address_d;
  logic                   srv_wr_ni_q,   srv_wr_ni_d;
  logic [DATA_WIDTH-1:0]  srv_dataW_q,   srv_dataW_d;

  logic                   found_s;
  logic [IDX_W-1:0]       sel_s;
  logic [ADDR_WIDTH-1:0]  addr_arr_s  [NUM_CLIENTS];
  logic [DATA_WIDTH-1:0]  dataw_arr_s [NUM_CLIENTS];

  // Unpack the flattened per-client address and write-data buses.
  for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
    assign addr_arr_s[gi]  = bus.address[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign dataw_arr_s[gi] = bus.dataW[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin scan: first requester at or after last+1, wrapping around.
  always_comb begin
    logic [IDX_W-1:0] cand;
    logic             hit;
    found_s = 1'b0;
    sel_s   = '0;
    cand    = '0;
    hit     = 1'b0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      cand    = IDX_W'((int'(last_q) + k) % NUM_CLIENTS);
      hit     = bus.rq[cand] & ~found_s;
      sel_s   = hit ? cand : sel_s;
      found_s = found_s | hit;
    end
  end

  // Transaction FSM next-state and output-register computation.
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    owner_d       = owner_q;
    grant_d       = grant_q;
    ack_d         = ack_q;
    dataR_d       = dataR_q;
    srv_req_d     = srv_req_q;
    srv_address_d = srv_address_q;
    srv_wr_ni_d   = srv_wr_ni_q;
    srv_dataW_d   = srv_dataW_q;
    case (state_q)
      ST_IDLE: begin
        ack_d     = '0;
        grant_d   = '0;
        srv_req_d = 1'b0;
        if (found_s) begin
          owner_d       = sel_s;
          grant_d       = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << sel_s;
          srv_req_d     = 1'b1;
          srv_address_d = addr_arr_s[sel_s];
          srv_wr_ni_d   = bus.wr_ni[sel_s];
          srv_dataW_d   = dataw_arr_s[sel_s];
          state_d       = ST_SERVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVE: begin
        // Client inputs are deliberately not looked at here: the captured
        // request runs to completion even if the client drops rq.
        if (bus.srv_ack) begin
          srv_req_d = 1'b0;
          dataR_d   = srv_wr_ni_q ? bus.srv_dataR : dataR_q;
          ack_d     = grant_q;
          last_d    = owner_q;
          state_d   = ST_ACK;
        end else begin
          state_d = ST_SERVE;
        end
      end
      ST_ACK: begin
        ack_d   = '0;
        grant_d = '0;
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Dead cycle so the acked client can withdraw rq before rescanning.
        state_d = ST_IDLE;
      end
      default: begin
        ack_d     = '0;
        grant_d   = '0;
        srv_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers; the pointer resets so client 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      last_q        <= IDX_W'(NUM_CLIENTS - 1);
      owner_q       <= '0;
      grant_q       <= '0;
      ack_q         <= '0;
      dataR_q       <= '0;
      srv_req_q     <= 1'b0;
      srv_address_q <= '0;
      srv_wr_ni_q   <= 1'b0;
      srv_dataW_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      owner_q       <= owner_d;
      grant_q       <= grant_d;
      ack_q         <= ack_d;
      dataR_q       <= dataR_d;
      srv_req_q     <= srv_req_d;
      srv_address_q <= srv_address_d;
      srv_wr_ni_q   <= srv_wr_ni_d;
      srv_dataW_q   <= srv_dataW_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.dataR       = dataR_q;
  assign bus.grant       = grant_q;
  assign bus.srv_req     = srv_req_q;
  assign bus.srv_address = srv_address_q;
  assign bus.srv_wr_ni   = srv_wr_ni_q;
  assign bus.srv_dataW   = srv_dataW_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed vector table, hand-written corner-case
// sequences and randomized traffic, all compared against a transaction-level
// reference model of the arbitration and timing rules.
module tb_bus_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset;

  bus_arbiter_if #(.NUM_CLIENTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  bus_arbiter #(.NUM_CLIENTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the bus, when the ack happened, when the
  // arbiter may grant again.
  int            m_cyc, m_last, m_owner, m_ack_edge, m_free_at;
  bit            m_active, m_wait;
  logic [AW-1:0] m_saddr;
  logic          m_swr;
  logic [DW-1:0] m_sdw, m_dataR;

  typedef struct {
    logic [N-1:0]    rq;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    wr;
    logic [N*DW-1:0] dw;
    logic            sack;
    logic [DW-1:0]   sdr;
    logic [N-1:0]    e_ack;
    logic [N-1:0]    e_grant;
    logic            e_req;
    logic [AW-1:0]   e_saddr;
    logic            e_swr;
    logic [DW-1:0]   e_sdw;
    logic [DW-1:0]   e_dataR;
  } vec_t;

  vec_t         vecs [9];
  logic [N-1:0] ack_seen [$];
  int           ack_cyc  [$];

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function void model_reset();
    m_active   = 1'b0;
    m_wait     = 1'b0;
    m_last     = N - 1;
    m_owner    = 0;
    m_ack_edge = -10;
    m_free_at  = 0;
    m_saddr    = '0;
    m_swr      = 1'b0;
    m_sdw      = '0;
    m_dataR    = '0;
  endfunction

  function void model_edge(input logic rst, input logic [N-1:0] rq,
                           input logic [N*AW-1:0] addr, input logic [N-1:0] wr,
                           input logic [N*DW-1:0] dw, input logic sack,
                           input logic [DW-1:0] sdr);
    m_cyc++;
    if (!rst) begin
      model_reset();
    end else if (!m_active) begin
      if (m_cyc >= m_free_at && rq != '0) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (rq[c]) begin
            m_owner = c;
            break;
          end
        end
        m_active = 1'b1;
        m_wait   = 1'b1;
        m_saddr  = addr[m_owner*AW +: AW];
        m_swr    = wr[m_owner];
        m_sdw    = dw[m_owner*DW +: DW];
      end
    end else if (m_wait) begin
      if (sack) begin
        m_wait     = 1'b0;
        m_ack_edge = m_cyc;
        m_last     = m_owner;
        if (m_swr) m_dataR = sdr;
      end
    end else if (m_cyc == m_ack_edge + 1) begin
      m_active  = 1'b0;
      m_free_at = m_cyc + 2;
    end
  endfunction

  function automatic logic [63:0] model_out();
    logic [N-1:0] a, g;
    a = (m_active && !m_wait && m_cyc == m_ack_edge) ? onehot(m_owner) : '0;
    g = m_active ? onehot(m_owner) : '0;
    return 64'({a, g, m_active && m_wait, m_saddr, m_swr, m_sdw, m_dataR});
  endfunction

  function automatic logic [63:0] dut_out();
    return 64'({bus_if.ack, bus_if.grant, bus_if.srv_req, bus_if.srv_address,
                bus_if.srv_wr_ni, bus_if.srv_dataW, bus_if.dataR});
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // One clock: sample inputs at the edge, advance the model, compare after.
  task automatic step();
    logic            r, sa;
    logic [N-1:0]    rq, wr;
    logic [N*AW-1:0] ad;
    logic [N*DW-1:0] dw;
    logic [DW-1:0]   sd;
    r  = reset;         rq = bus_if.rq;    ad = bus_if.address; wr = bus_if.wr_ni;
    dw = bus_if.dataW;  sa = bus_if.srv_ack; sd = bus_if.srv_dataR;
    @(posedge clk);
    model_edge(r, rq, ad, wr, dw, sa, sd);
    #1;
    check("model", dut_out(), model_out());
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check("reset_async", dut_out(), 64'd0);
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset            = 1'b1;
    m_cyc            = 0;
    bus_if.rq        = '0;
    bus_if.address   = '0;
    bus_if.wr_ni     = '0;
    bus_if.dataW     = '0;
    bus_if.srv_ack   = 1'b0;
    bus_if.srv_dataR = '0;
    model_reset();

    //            rq       addr       wr       dw            sack  sdr     ack      grant    req   saddr wr    sdw     dataR
    vecs[0] = '{4'b0001, 16'h0003, 4'b0000, 32'h00000055, 1'b0, 8'h11, 4'b0000, 4'b0001, 1'b1, 4'h3, 1'b0, 8'h55, 8'h00};
    vecs[1] = '{4'b0001, 16'h0003, 4'b0000, 32'h00000055, 1'b0, 8'h11, 4'b0000, 4'b0001, 1'b1, 4'h3, 1'b0, 8'h55, 8'h00};
    vecs[2] = '{4'b0001, 16'h0003, 4'b0000, 32'h00000055, 1'b1, 8'h77, 4'b0001, 4'b0001, 1'b0, 4'h3, 1'b0, 8'h55, 8'h00};
    vecs[3] = '{4'b0000, 16'h0003, 4'b0000, 32'h00000055, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 4'h3, 1'b0, 8'h55, 8'h00};
    vecs[4] = '{4'b0000, 16'h0003, 4'b0000, 32'h00000055, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 4'h3, 1'b0, 8'h55, 8'h00};
    vecs[5] = '{4'b0100, 16'h0700, 4'b0100, 32'h00990000, 1'b0, 8'h00, 4'b0000, 4'b0100, 1'b1, 4'h7, 1'b1, 8'h99, 8'h00};
    vecs[6] = '{4'b0100, 16'h0700, 4'b0100, 32'h00990000, 1'b1, 8'hA5, 4'b0100, 4'b0100, 1'b0, 4'h7, 1'b1, 8'h99, 8'hA5};
    vecs[7] = '{4'b0000, 16'h0700, 4'b0100, 32'h00990000, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 4'h7, 1'b1, 8'h99, 8'hA5};
    vecs[8] = '{4'b0000, 16'h0700, 4'b0100, 32'h00990000, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 4'h7, 1'b1, 8'h99, 8'hA5};

    #2;
    apply_reset();

    // Directed write by client 0, then read by client 2.
    for (int i = 0; i < 9; i++) begin
      bus_if.rq = vecs[i].rq;   bus_if.address = vecs[i].addr; bus_if.wr_ni = vecs[i].wr;
      bus_if.dataW = vecs[i].dw; bus_if.srv_ack = vecs[i].sack; bus_if.srv_dataR = vecs[i].sdr;
      step();
      check($sformatf("vec%0d", i), dut_out(),
            64'({vecs[i].e_ack, vecs[i].e_grant, vecs[i].e_req, vecs[i].e_saddr,
                 vecs[i].e_swr, vecs[i].e_sdw, vecs[i].e_dataR}));
    end

    // All four requesting with a zero-wait server: strict rotation, 4 cycles apart.
    apply_reset();
    bus_if.rq = 4'b1111; bus_if.srv_ack = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      if (bus_if.ack != '0) begin
        ack_seen.push_back(bus_if.ack);
        ack_cyc.push_back(i);
      end
    end
    check("rr_count_ge5", 64'(ack_seen.size() >= 5), 64'd1);
    for (int i = 0; i < 5 && i < ack_seen.size(); i++) begin
      check($sformatf("rr_order%0d", i), 64'(ack_seen[i]), 64'(onehot(i % 4)));
      if (i > 0) check($sformatf("rr_gap%0d", i), 64'(ack_cyc[i] - ack_cyc[i-1]), 64'd4);
    end

    // Pointer at client 1: 1001 must wrap from index 2 and grant client 3 first.
    apply_reset();
    bus_if.rq = 4'b0010; bus_if.srv_ack = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus_if.rq = 4'b1001;
    step();
    check("wrap_first", 64'(bus_if.grant), 64'(4'b1000));
    for (int i = 0; i < 4; i++) step();
    check("wrap_second", 64'(bus_if.grant), 64'(4'b0001));
    bus_if.rq = 4'b0000; bus_if.srv_ack = 1'b0;
    step();

    // Client 1 drops rq and changes dataW mid-transaction.
    apply_reset();
    bus_if.rq = 4'b0010; bus_if.address = 16'h0050; bus_if.wr_ni = 4'b0000;
    bus_if.dataW = 32'h00003C00; bus_if.srv_ack = 1'b0;
    step();
    bus_if.rq = 4'b0000; bus_if.dataW = 32'h0000C300; bus_if.address = 16'h00A0;
    step();
    step();
    check("hold_dataW", 64'(bus_if.srv_dataW), 64'(8'h3C));
    check("hold_addr", 64'(bus_if.srv_address), 64'(4'h5));
    check("hold_req", 64'(bus_if.srv_req), 64'd1);
    bus_if.srv_ack = 1'b1;
    step();
    check("drop_ack", 64'(bus_if.ack), 64'(4'b0010));
    bus_if.srv_ack = 1'b0;
    step();
    step();

    // Reset in the middle of SERVE aborts at once; IDLE grants again after release.
    apply_reset();
    bus_if.rq = 4'b0100;
    step();
    check("abort_pre_req", 64'(bus_if.srv_req), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("abort_req", 64'(bus_if.srv_req), 64'd0);
    check("abort_grant", 64'(bus_if.grant), 64'd0);
    check("abort_ack", 64'(bus_if.ack), 64'd0);
    step();
    step();
    reset = 1'b1;
    bus_if.rq = 4'b0010;
    step();
    check("abort_regrant", 64'(bus_if.grant), 64'(4'b0010));

    // Randomized traffic with occasional resets, checked by the model each cycle.
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset();
      end else begin
        bus_if.rq        = N'($urandom);
        bus_if.address   = (N*AW)'($urandom);
        bus_if.wr_ni     = N'($urandom);
        bus_if.dataW     = (N*DW)'($urandom);
        bus_if.srv_ack   = ($urandom_range(0, 2) == 0);
        bus_if.srv_dataR = DW'($urandom);
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
